// File: rtl/dm_arb.sv
// Two-master arbiter/sequencer for a word-wide data memory with byte/half RMW stores.
// Build option: define DM_ARB_FIXED_PRIO_EN for fixed m0 priority instead of round-robin.
module dm_arb #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [1:0]        m0_size,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [1:0]        m1_size,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_ACK} state_t;

  state_t              r_state, w_state_nxt;
  logic                w_any_req, w_gnt1;
  logic                w_sel_we, w_sel_err;
  logic [1:0]          w_sel_size;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic                r_id, r_we, r_err;
  logic [1:0]          r_size, r_lane;
  logic [15:0]         r_wdata;
  logic                w_ack_nxt, w_id_nxt, w_err_nxt;
  logic [4:0]          w_shamt;
  logic [DATA_W-1:0]   w_lane_data, w_ld_data, w_ins, w_mask, w_merged;
  logic                r_m0_ack, r_m0_err, r_m1_ack, r_m1_err, r_mem_we;
  logic [DATA_W-1:0]   r_m0_rdata, r_m1_rdata, r_mem_din;
  logic [ADDR_W-1:0]   r_mem_addr;

  assign w_any_req = m0_req | m1_req;

`ifdef DM_ARB_FIXED_PRIO_EN
  assign w_gnt1 = m1_req & ~m0_req;
`else
  logic r_rr;
  // r_rr=1 prefers m1 on a tie; after each grant it points at the other master
  assign w_gnt1 = m1_req & (~m0_req | r_rr);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  r_rr <= 1'b0;
    else if (r_state == S_ACK) r_rr <= ~r_id;
  end
`endif

  // Winner's request fields and alignment/size error check
  always_comb begin
    w_sel_we    = w_gnt1 ? m1_we    : m0_we;
    w_sel_size  = w_gnt1 ? m1_size  : m0_size;
    w_sel_addr  = w_gnt1 ? m1_addr  : m0_addr;
    w_sel_wdata = w_gnt1 ? m1_wdata : m0_wdata;
    w_sel_err   = (w_sel_size == 2'd3) ||
                  ((w_sel_size == 2'd1) && w_sel_addr[0]) ||
                  ((w_sel_size == 2'd2) && (w_sel_addr[1:0] != 2'b00));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          if (w_sel_err)                             w_state_nxt = S_ACK;
          else if (w_sel_we && (w_sel_size == 2'd2)) w_state_nxt = S_WR;
          else                                       w_state_nxt = S_RD;
        end
      end
      S_RD:    w_state_nxt = S_CAP;
      S_CAP:   w_state_nxt = r_we ? S_WR : S_ACK;
      S_WR:    w_state_nxt = S_ACK;
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Lane extraction for loads and lane merge for sub-word stores
  always_comb begin
    w_ack_nxt   = (w_state_nxt == S_ACK);
    w_id_nxt    = (r_state == S_IDLE) ? w_gnt1    : r_id;
    w_err_nxt   = (r_state == S_IDLE) ? w_sel_err : r_err;
    w_shamt     = {r_lane, 3'b000};
    w_lane_data = mem_dout >> w_shamt;
    case (r_size)
      2'd0:    w_ld_data = DATA_W'(w_lane_data[7:0]);
      2'd1:    w_ld_data = DATA_W'(w_lane_data[15:0]);
      default: w_ld_data = mem_dout;
    endcase
    w_ins    = (r_size == 2'd0) ? DATA_W'(r_wdata[7:0]) : DATA_W'(r_wdata);
    w_mask   = ((r_size == 2'd0) ? DATA_W'(32'h0000_00FF) : DATA_W'(32'h0000_FFFF)) << w_shamt;
    w_merged = (mem_dout & ~w_mask) | (w_ins << w_shamt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id       <= 1'b0;
      r_we       <= 1'b0;
      r_err      <= 1'b0;
      r_size     <= 2'd0;
      r_lane     <= 2'd0;
      r_wdata    <= 16'd0;
      r_m0_ack   <= 1'b0;
      r_m0_err   <= 1'b0;
      r_m1_ack   <= 1'b0;
      r_m1_err   <= 1'b0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      r_mem_we   <= 1'b0;
    end else begin
      r_m0_ack <= w_ack_nxt & ~w_id_nxt;
      r_m1_ack <= w_ack_nxt &  w_id_nxt;
      r_m0_err <= w_ack_nxt & ~w_id_nxt & w_err_nxt;
      r_m1_err <= w_ack_nxt &  w_id_nxt & w_err_nxt;
      r_mem_we <= (w_state_nxt == S_WR);
      if ((r_state == S_IDLE) && w_any_req) begin
        r_id    <= w_gnt1;
        r_we    <= w_sel_we;
        r_err   <= w_sel_err;
        r_size  <= w_sel_size;
        r_lane  <= w_sel_addr[1:0];
        r_wdata <= w_sel_wdata[15:0];
        if (!w_sel_err) r_mem_addr <= {w_sel_addr[ADDR_W-1:2], 2'b00};
        if (w_state_nxt == S_WR) r_mem_din <= w_sel_wdata;
      end
      if (r_state == S_CAP) begin
        if (r_we)      r_mem_din  <= w_merged;
        else if (r_id) r_m1_rdata <= w_ld_data;
        else           r_m0_rdata <= w_ld_data;
      end
    end
  end

  assign m0_ack   = r_m0_ack;
  assign m0_err   = r_m0_err;
  assign m0_rdata = r_m0_rdata;
  assign m1_ack   = r_m1_ack;
  assign m1_err   = r_m1_err;
  assign m1_rdata = r_m1_rdata;
  assign mem_addr = r_mem_addr;
  assign mem_din  = r_mem_din;
  assign mem_we   = r_mem_we;

endmodule

// File: tb/tb_dm_arb.sv
// Directed bench for dm_arb with a synchronous-read word memory model.
module tb_dm_arb;
  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [1:0]  m0_size, m1_size;
  logic [9:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [9:0]  mem_addr;
  logic [31:0] mem_din, mem_dout;
  logic        mem_we;

  logic [31:0] mem [0:255];
  int total = 0, bad = 0;
  logic [31:0] g_rd, g_din;
  logic        g_err;
  int          g_cyc, g_nwe, g_wecyc;
  int          first, second;

  always #5 clk = ~clk;

  dm_arb dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
  );

  always @(posedge clk) begin
    mem_dout <= mem[mem_addr[9:2]];
    if (mem_we) mem[mem_addr[9:2]] <= mem_din;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Issue one request from the IDLE cycle (cycle 0) and wait for its ack
  task automatic xfer(input int m, input logic we, input logic [1:0] sz,
                      input logic [9:0] a, input logic [31:0] wd);
    bit done = 0;
    if (m == 0) begin m0_req = 1; m0_we = we; m0_size = sz; m0_addr = a; m0_wdata = wd; end
    else        begin m1_req = 1; m1_we = we; m1_size = sz; m1_addr = a; m1_wdata = wd; end
    g_cyc = 0; g_nwe = 0; g_wecyc = 0; g_din = 0; g_rd = 0; g_err = 0;
    while (!done && g_cyc < 20) begin
      @(negedge clk);
      g_cyc++;
      if (mem_we) begin
        g_nwe++; g_wecyc = g_cyc; g_din = mem_din;
        check("wr_align", 32'(mem_addr[1:0]), 0);
      end
      if (m == 0 && m0_ack) begin done = 1; g_rd = m0_rdata; g_err = m0_err; m0_req = 0; end
      if (m == 1 && m1_ack) begin done = 1; g_rd = m1_rdata; g_err = m1_err; m1_req = 0; end
    end
    if (!done) begin
      check("ack_timeout", 0, 1);
      m0_req = 0; m1_req = 0;
    end
    @(negedge clk);
    check("ack_one_cycle", (m == 0) ? m0_ack : m1_ack, 0);
  endtask

  // Both masters issue word loads at once; records grant order
  task automatic both();
    m0_req = 1; m0_we = 0; m0_size = 2; m0_addr = 10'h010;
    m1_req = 1; m1_we = 0; m1_size = 2; m1_addr = 10'h020;
    first = -1; second = -1;
    for (int c = 0; c < 20 && second < 0; c++) begin
      @(negedge clk);
      if (m0_ack) begin m0_req = 0; if (first < 0) first = 0; else second = 0; end
      if (m1_ack) begin m1_req = 0; if (first < 0) first = 1; else second = 1; end
    end
    m0_req = 0; m1_req = 0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1;
    m0_req = 0; m0_we = 0; m0_size = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_size = 0; m1_addr = 0; m1_wdata = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[4] = 32'hDDCCBBAA;
    repeat (2) @(negedge clk);
    check("rst_m0_ack", m0_ack, 0);
    check("rst_m0_err", m0_err, 0);
    check("rst_m0_rdata", m0_rdata, 0);
    check("rst_m1_ack", m1_ack, 0);
    check("rst_m1_rdata", m1_rdata, 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_din", mem_din, 0);
    check("rst_mem_we", mem_we, 0);
    rst = 0;
    @(negedge clk);

    xfer(0, 0, 0, 10'h012, 0);
    check("ldb_rdata", g_rd, 32'h000000CC);
    check("ldb_cyc", g_cyc, 3);
    check("ldb_nwe", g_nwe, 0);
    check("ldb_err", g_err, 0);

    xfer(0, 1, 1, 10'h012, 32'h0000BEEF);
    check("sth_cyc", g_cyc, 4);
    check("sth_nwe", g_nwe, 1);
    check("sth_wecyc", g_wecyc, 3);
    check("sth_din", g_din, 32'hBEEFBBAA);
    check("sth_rdata_kept", m0_rdata, 32'h000000CC);
    check("sth_mem", mem[4], 32'hBEEFBBAA);

    xfer(1, 0, 2, 10'h010, 0);
    check("ldw_rdata", g_rd, 32'hBEEFBBAA);
    check("ldw_cyc", g_cyc, 3);

    xfer(0, 1, 2, 10'h020, 32'h12345678);
    check("stw_cyc", g_cyc, 2);
    check("stw_wecyc", g_wecyc, 1);
    check("stw_din", g_din, 32'h12345678);
    check("stw_mem", mem[8], 32'h12345678);

    xfer(1, 0, 2, 10'h013, 0);
    check("errw_cyc", g_cyc, 1);
    check("errw_err", g_err, 1);
    check("errw_rdata", g_rd, 32'hBEEFBBAA);
    check("errw_nwe", g_nwe, 0);
    xfer(1, 0, 3, 10'h010, 0);
    check("errsz_cyc", g_cyc, 1);
    check("errsz_err", g_err, 1);
    check("errsz_rdata", g_rd, 32'hBEEFBBAA);
    xfer(0, 1, 1, 10'h011, 32'h1111);
    check("errh_err", g_err, 1);
    check("errh_nwe", g_nwe, 0);
    check("errh_mem", mem[4], 32'hBEEFBBAA);

    rst = 1; @(negedge clk); rst = 0; @(negedge clk);
    both();
    check("arb1_first", first, 0);
    check("arb1_second", second, 1);
    check("arb1_m0_rdata", m0_rdata, 32'hBEEFBBAA);
    check("arb1_m1_rdata", m1_rdata, 32'h12345678);
    both();
    check("arb2_first", first, 0);
    check("arb2_second", second, 1);
    xfer(0, 0, 2, 10'h010, 0);
    both();
`ifdef DM_ARB_FIXED_PRIO_EN
    check("arb3_first", first, 0);
    check("arb3_second", second, 1);
`else
    check("arb3_first", first, 1);
    check("arb3_second", second, 0);
`endif

    mem[4] = 32'hDDCCBBAA;
    m0_req = 1; m0_we = 1; m0_size = 0; m0_addr = 10'h011; m0_wdata = 32'h55;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    #1;
    check("abort_we_now", mem_we, 0);
    check("abort_ack_now", m0_ack, 0);
    @(negedge clk);
    check("abort_we", mem_we, 0);
    check("abort_ack", m0_ack, 0);
    check("abort_mem", mem[4], 32'hDDCCBBAA);
    rst = 0;
    xfer(0, 1, 0, 10'h011, 32'h55);
    check("retry_cyc", g_cyc, 4);
    check("retry_nwe", g_nwe, 1);
    check("retry_din", g_din, 32'hDDCC55AA);
    xfer(1, 0, 2, 10'h010, 0);
    check("retry_read", g_rd, 32'hDDCC55AA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
